bitstream_generator: RTL and testbench

BITSTREAM_GENERATOR -- requirements
Module: bitstream_generator

---
 rtl/bitstream_generator.sv | 123 ++++++++++++
 tb/tb_bitstream_generator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_generator.sv
// -----------------------------------------------------------------------------
// bitstream_generator
//
// Emits one stochastic bitstream of LENGTH cycles per accepted start. Each
// window bit is 1 when the current 8-bit LFSR state is <= the latched
// probability numerator. A maximal-length LFSR visits every value 1..255
// exactly once per period. A 255-cycle window therefore holds exactly
// value_q ones.
//
// Parameters
//   LENGTH   stream length in clock cycles, legal range 1..65535
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   start    begin one stream, sampled only while idle
//   abort    synchronous terminate of the running stream, no done pulse
//   value    probability numerator, latched on accepted start
//   seed     LFSR seed, latched on accepted start (0 is mapped to 1)
//   x        registered stream bit, aligned with capture
//   capture  registered stream window, high for exactly LENGTH cycles
//   busy     high whenever the FSM is not idle
//   done     one-cycle pulse after a stream completes normally
// -----------------------------------------------------------------------------
module bitstream_generator #(
    parameter int unsigned LENGTH = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] value,
    input  logic [7:0] seed,
    output logic       x,
    output logic       capture,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] LAST = 16'(LENGTH - 1);

    state_t      state_q;
    logic [7:0]  value_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  lfsr_d;
    logic [7:0]  seed_d;
    logic [15:0] cnt_q;
    logic        x_q;
    logic        capture_q;
    logic        done_q;

    // Fibonacci taps 7,5,4,3. A zero seed would lock the LFSR at zero, so it is replaced by 1.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        seed_d = (seed == '0) ? 8'h01 : seed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            value_q   <= '0;
            lfsr_q    <= 8'h01;
            cnt_q     <= '0;
            x_q       <= 1'b0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    x_q       <= 1'b0;
                    capture_q <= 1'b0;
                    // abort has priority over a simultaneous start
                    if (start && !abort) begin
                        value_q <= value;
                        lfsr_q  <= seed_d;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        x_q       <= 1'b0;
                        capture_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        x_q       <= (lfsr_q <= value_q);
                        capture_q <= 1'b1;
                        lfsr_q    <= lfsr_d;
                        cnt_q     <= cnt_q + 16'd1;
                        // last bit is emitted on the same edge that leaves RUN
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    x_q       <= 1'b0;
                    capture_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    x_q       <= 1'b0;
                    capture_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign capture = capture_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bitstream_generator.sv
module tb_bitstream_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic       abort;
    logic [7:0] value;
    logic [7:0] seed;
    logic       x, capture, busy, done;
    logic       x1, capture1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    logic got_q[$];
    logic seq_a[$];

    always #5 clk = ~clk;

    bitstream_generator #(.LENGTH(255)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .value(value), .seed(seed),
        .x(x), .capture(capture), .busy(busy), .done(done)
    );

    bitstream_generator #(.LENGTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .value(value), .seed(seed),
        .x(x1), .capture(capture1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR step: feedback is the parity of taps 7,5,4,3.
    function automatic logic [7:0] ref_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    // One stream on the LENGTH=255 instance. abort_at/rst_at: window cycle to
    // disturb at (0 = never). pester: re-pulse start and alter value mid-stream
    // and during the DONE cycle.
    task automatic run_stream(input logic [7:0] v, input logic [7:0] s,
                              input int abort_at, input int rst_at,
                              input bit pester, input string tag);
        int win = 0;
        int ones = 0;
        int errs = 0;
        int cyc = 0;
        bit ended = 0;
        logic any_done;
        logic [7:0] l;
        l = (s == 8'h00) ? 8'h01 : s;
        got_q.delete();
        value = v;
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_run"}, busy, 1);
        check({tag, "_cap_lat"}, capture, 0);
        while (!ended && cyc < 600) begin
            step();
            cyc++;
            if (capture) begin
                got_q.push_back(x);
                if (x) ones++;
                if (x !== (l <= v)) errs++;
                l = ref_next(l);
                win++;
                if (pester && win == 10) begin
                    start = 1'b1;
                    value = 8'd3;
                    seed  = 8'h5A;
                end else if (pester && win == 11) begin
                    start = 1'b0;
                end
                if (pester && win == 255) start = 1'b1;
                if (win == abort_at) abort = 1'b1;
                if (win == rst_at) begin
                    #2 rst = 1'b1;
                    #1;
                    check({tag, "_rst_cap"}, capture, 0);
                    check({tag, "_rst_x"}, x, 0);
                    check({tag, "_rst_busy"}, busy, 0);
                    check({tag, "_rst_bits"}, errs, 0);
                    @(posedge clk);
                    #1 rst = 1'b0;
                    any_done = 1'b0;
                    repeat (4) begin
                        step();
                        any_done = any_done | done;
                    end
                    check({tag, "_rst_nodone"}, any_done, 0);
                    check({tag, "_rst_idle"}, busy, 0);
                    ended = 1;
                end
            end else if (win > 0) begin
                ended = 1;
                if (abort_at > 0) begin
                    abort = 1'b0;
                    check({tag, "_abort_win"}, win, abort_at);
                    check({tag, "_abort_x"}, x, 0);
                    check({tag, "_abort_busy"}, busy, 0);
                    check({tag, "_abort_bits"}, errs, 0);
                    any_done = done;
                    repeat (3) begin
                        step();
                        any_done = any_done | done;
                    end
                    check({tag, "_abort_nodone"}, any_done, 0);
                end else begin
                    check({tag, "_window"}, win, 255);
                    check({tag, "_ones"}, ones, {24'd0, v});
                    check({tag, "_seq"}, errs, 0);
                    check({tag, "_done"}, done, 1);
                    check({tag, "_busy_end"}, busy, 0);
                    start = 1'b0;
                    step();
                    check({tag, "_done_pulse"}, done, 0);
                    check({tag, "_no_queue"}, busy, 0);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!ended) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int diff;
        logic [7:0] rv;
        logic [7:0] rs;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        abort  = 1'b0;
        value  = 8'd0;
        seed   = 8'd0;
        repeat (2) step();
        check("rst_x", x, 0);
        check("rst_cap", capture, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_busy1", busy1, 0);
        check("rst_cap1", capture1, 0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_wait", busy, 0);

        run_stream(8'd128, 8'h01, 0, 0, 0, "c1");
        run_stream(8'd0,   8'h01, 0, 0, 0, "c2_v0_s1");
        run_stream(8'd255, 8'h01, 0, 0, 0, "c2_v255_s1");
        run_stream(8'd0,   8'hA5, 0, 0, 0, "c2_v0_sA5");
        run_stream(8'd255, 8'hA5, 0, 0, 0, "c2_v255_sA5");

        run_stream(8'd77, 8'h00, 0, 0, 0, "c3_s0");
        seq_a = got_q;
        run_stream(8'd77, 8'h01, 0, 0, 0, "c3_s1");
        check("c3_len", got_q.size(), seq_a.size());
        diff = 0;
        foreach (seq_a[i]) if (i < got_q.size() && got_q[i] !== seq_a[i]) diff++;
        check("c3_identical", diff, 0);

        run_stream(8'd200, 8'h3C, 0, 0, 1, "c4");

        run_stream(8'd150, 8'h11, 50, 0, 0, "c5_abort");
        run_stream(8'd150, 8'h11, 0, 0, 0, "c5_after");

        abort = 1'b1;
        start = 1'b1;
        value = 8'd9;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 0);
        step();
        check("abort_beats_start_cap", capture, 0);

        run_stream(8'd90, 8'h22, 0, 100, 0, "c6_rst");
        run_stream(8'd40, 8'h22, 0, 0, 0, "c6_after");

        repeat (8) begin
            rv = 8'($urandom_range(0, 255));
            rs = 8'($urandom_range(0, 255));
            run_stream(rv, rs, 0, 0, 0, "rand");
        end

        // LENGTH=1 instance: single-cycle window
        for (int k = 0; k < 2; k++) begin
            value  = (k == 0) ? 8'd255 : 8'd0;
            seed   = 8'h01;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("l1_busy", busy1, 1);
            check("l1_cap_lat", capture1, 0);
            step();
            check("l1_cap", capture1, 1);
            check("l1_x", x1, (k == 0) ? 1 : 0);
            step();
            check("l1_cap_end", capture1, 0);
            check("l1_done", done1, 1);
            check("l1_idle", busy1, 0);
            step();
            check("l1_done_pulse", done1, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
